// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Optional counters are enabled by defining ARB_PERF_CNT_EN.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int BURST_W_DEF      = 8;
   localparam int ACC_MAX_WAIT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACC_BURST = 2'd1,
      HANDBACK  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;

   // A zero-length burst request still moves one beat.
   function automatic logic [BURST_W_DEF-1:0] burst_len_fix(
      input logic [BURST_W_DEF-1:0] len
   );
      return (len == '0) ? BURST_W_DEF'(1) : len;
   endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating accelerator wait counter with synchronous clear.
// Feeds the starvation override of the arbiter FSM.
module dmem_arb_starve_cnt
   import dmem_arb_pkg::*;
#(
   parameter int MAX   = ACC_MAX_WAIT_DEF,
   parameter int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_sat
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_sat;

   assign w_sat = (r_cnt == CNT_W'(MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_sat = w_sat;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU by default, accelerator bursts with starvation bound.
// Define ARB_PERF_CNT_EN to add perf_cpu_stall / perf_acc_beats counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int BURST_W      = BURST_W_DEF,
   parameter int ACC_MAX_WAIT = ACC_MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_mem_en,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              acc_req,
   input  logic [BURST_W-1:0] acc_burst_len,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              acc_gnt,
   output logic              acc_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cpu_stall,
   output logic [31:0]       perf_acc_beats
`endif
);

   localparam int WAIT_W = $clog2(ACC_MAX_WAIT + 1);

   arb_state_t       r_state;
   arb_state_t       w_next;
   logic [BURST_W-1:0] r_beat_cnt;
   logic [BURST_W-1:0] r_len_q;
   logic [BURST_W-1:0] w_len_lat;
   logic [WAIT_W-1:0]  w_wait_cnt;
   logic               w_wait_sat;
   logic               w_idle_req;
   logic               w_go;
   logic               w_gnt;
   logic               w_last;
   mem_req_t           w_cpu_req;
   mem_req_t           w_acc_req;
   mem_req_t           w_req;

   assign w_len_lat  = (acc_burst_len == '0) ? BURST_W'(1) : acc_burst_len;
   assign w_idle_req = (r_state == IDLE) && acc_req;
   assign w_go       = w_idle_req && (!cpu_mem_en || w_wait_sat);

   dmem_arb_starve_cnt #(
      .MAX   (ACC_MAX_WAIT),
      .CNT_W (WAIT_W)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_idle_req),
      .i_clr (!w_idle_req || w_go),
      .o_cnt (w_wait_cnt),
      .o_sat (w_wait_sat)
   );

   assign w_gnt  = (r_state == ACC_BURST) && acc_req;
   assign w_last = w_gnt && (r_beat_cnt == (r_len_q - BURST_W'(1)));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      if (w_go) w_next = ACC_BURST;
         ACC_BURST: if (w_last || !acc_req) w_next = HANDBACK;
         HANDBACK:  w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_len_q    <= '0;
      end else begin
         r_state <= w_next;
         if (w_go) begin
            r_len_q    <= w_len_lat;
            r_beat_cnt <= '0;
         end else if (w_gnt) begin
            r_beat_cnt <= r_beat_cnt + BURST_W'(1);
         end
      end
   end

   assign w_cpu_req = '{
      we:    cpu_we & cpu_mem_en,
      addr:  ADDR_W_DEF'(cpu_addr),
      wdata: DATA_W_DEF'(cpu_wdata)
   };
   assign w_acc_req = '{
      we:    acc_we & acc_req,
      addr:  ADDR_W_DEF'(acc_addr),
      wdata: DATA_W_DEF'(acc_wdata)
   };

   // Every output is forced low while reset is held, including mid-burst.
   always_comb begin
      w_req     = '0;
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      acc_rdata = '0;
      acc_gnt   = 1'b0;
      acc_last  = 1'b0;
      if (reset) begin
         unique case (r_state)
            ACC_BURST: begin
               w_req     = w_acc_req;
               acc_rdata = mem_rdata;
               acc_gnt   = w_gnt;
               acc_last  = w_last;
               cpu_stall = cpu_mem_en;
            end
            IDLE, HANDBACK: begin
               w_req     = w_cpu_req;
               cpu_rdata = mem_rdata;
            end
            default: begin
               w_req = '0;
            end
         endcase
      end
   end

   assign mem_we    = w_req.we;
   assign mem_addr  = ADDR_W'(w_req.addr);
   assign mem_wdata = DATA_W'(w_req.wdata);

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_cpu_stall_cycles;
   logic [31:0] r_acc_grant_beats;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpu_stall_cycles <= '0;
         r_acc_grant_beats  <= '0;
      end else begin
         if (cpu_stall) r_cpu_stall_cycles <= r_cpu_stall_cycles + 32'd1;
         if (acc_gnt)   r_acc_grant_beats  <= r_acc_grant_beats + 32'd1;
      end
   end

   assign perf_cpu_stall = r_cpu_stall_cycles;
   assign perf_acc_beats = r_acc_grant_beats;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
// Counter checks are included when ARB_PERF_CNT_EN is defined.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        cpu_mem_en;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        acc_req;
   logic [7:0]  acc_burst_len;
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [31:0] acc_rdata;
   logic        acc_gnt;
   logic        acc_last;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_cpu_stall;
   logic [31:0] perf_acc_beats;
   logic [31:0] snap_stall;
   logic [31:0] snap_beats;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:255];

   dmem_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_mem_en    (cpu_mem_en),
      .cpu_we        (cpu_we),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .cpu_stall     (cpu_stall),
      .acc_req       (acc_req),
      .acc_burst_len (acc_burst_len),
      .acc_we        (acc_we),
      .acc_addr      (acc_addr),
      .acc_wdata     (acc_wdata),
      .acc_rdata     (acc_rdata),
      .acc_gnt       (acc_gnt),
      .acc_last      (acc_last),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_cpu_stall(perf_cpu_stall),
      .perf_acc_beats(perf_acc_beats)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      reset         = 1'b0;
      cpu_mem_en    = 1'b1;
      cpu_we        = 1'b1;
      cpu_addr      = 32'h40;
      cpu_wdata     = 32'h1111_2222;
      acc_req       = 1'b0;
      acc_burst_len = 8'd0;
      acc_we        = 1'b0;
      acc_addr      = 32'h0;
      acc_wdata     = 32'h0;

      // outputs held low in reset
      #2;
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_gnt", acc_gnt, 0);
      @(negedge clk);
      reset      = 1'b1;
      cpu_mem_en = 1'b0;
      cpu_we     = 1'b0;

      // 1: CPU write then read
      tick();
      cpu_mem_en = 1'b1;
      cpu_we     = 1'b1;
      cpu_addr   = 32'h40;
      cpu_wdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_mem_we", mem_we, 1);
      chk("t1_mem_addr", mem_addr, 32'h40);
      chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t1_stall", cpu_stall, 0);
      tick();
      cpu_we = 1'b0;
      @(negedge clk);
      chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("t1_rd_we", mem_we, 0);

      // 2: accelerator burst of 4 with idle CPU
      tick();
      cpu_mem_en    = 1'b0;
      acc_req       = 1'b1;
      acc_burst_len = 8'd4;
      acc_addr      = 32'h40;
      @(negedge clk);
      chk("t2_arb_gnt", acc_gnt, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         chk("t2_gnt", acc_gnt, 1);
         chk("t2_last", acc_last, (i == 3) ? 1 : 0);
      end
      chk("t2_acc_rdata", acc_rdata, 32'hDEAD_BEEF);
      chk("t2_mem_addr", mem_addr, 32'h40);
      tick();
      cpu_mem_en = 1'b1;
      cpu_we     = 1'b1;
      cpu_addr   = 32'h44;
      cpu_wdata  = 32'h0000_1234;
      @(negedge clk);
      chk("t2_hb_gnt", acc_gnt, 0);
      chk("t2_hb_stall", cpu_stall, 0);
      chk("t2_hb_we", mem_we, 1);
      chk("t2_hb_acc_rdata", acc_rdata, 0);
      tick();
      acc_req    = 1'b0;
      cpu_we     = 1'b0;
      @(negedge clk);
      chk("t2_idle_gnt", acc_gnt, 0);
      chk("t2_idle_rdata", cpu_rdata, 32'h0000_1234);

      // 3: starvation bound with CPU busy every cycle
      tick();
      cpu_addr      = 32'h40;
      acc_req       = 1'b1;
      acc_burst_len = 8'd2;
`ifdef ARB_PERF_CNT_EN
      snap_stall = perf_cpu_stall;
      snap_beats = perf_acc_beats;
`endif
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         chk("t3_wait_gnt", acc_gnt, 0);
         if (k < 16) tick();
      end
      chk("t3_wait_stall", cpu_stall, 0);
      tick();
      @(negedge clk);
      chk("t3_gnt1", acc_gnt, 1);
      chk("t3_stall1", cpu_stall, 1);
      chk("t3_cpu_rdata", cpu_rdata, 0);
      tick();
      @(negedge clk);
      chk("t3_gnt2", acc_gnt, 1);
      chk("t3_last2", acc_last, 1);
      chk("t3_stall2", cpu_stall, 1);
      tick();
      acc_req = 1'b0;
      @(negedge clk);
      chk("t3_hb_stall", cpu_stall, 0);
      chk("t3_hb_rdata", cpu_rdata, 32'hDEAD_BEEF);
`ifdef ARB_PERF_CNT_EN
      chk("t3_perf_stall", perf_cpu_stall - snap_stall, 2);
      chk("t3_perf_beats", perf_acc_beats - snap_beats, 2);
`endif

      // 4: abort after 3 of 8 beats, then re-request with len 2
      tick();
      cpu_mem_en    = 1'b0;
      tick();
      acc_req       = 1'b1;
      acc_burst_len = 8'd8;
      acc_we        = 1'b1;
      acc_addr      = 32'h100;
      acc_wdata     = 32'h0000_00A5;
      @(negedge clk);
      chk("t4_arb_gnt", acc_gnt, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("t4_gnt", acc_gnt, 1);
         chk("t4_last", acc_last, 0);
      end
      chk("t4_acc_we", mem_we, 1);
      tick();
      acc_req = 1'b0;
      acc_we  = 1'b0;
      @(negedge clk);
      chk("t4_abort_gnt", acc_gnt, 0);
      chk("t4_abort_last", acc_last, 0);
      tick();
      @(negedge clk);
      chk("t4_hb_gnt", acc_gnt, 0);
      tick();
      acc_req       = 1'b1;
      acc_burst_len = 8'd2;
      @(negedge clk);
      chk("t4_re_arb", acc_gnt, 0);
      tick();
      @(negedge clk);
      chk("t4_re_last1", acc_last, 0);
      tick();
      @(negedge clk);
      chk("t4_re_gnt2", acc_gnt, 1);
      chk("t4_re_last2", acc_last, 1);
      tick();
      acc_req = 1'b0;
      @(negedge clk);
      chk("t4_re_hb", acc_gnt, 0);

      // 5: zero length gives one beat
      tick();
      acc_req       = 1'b1;
      acc_burst_len = 8'd0;
      @(negedge clk);
      chk("t5_arb", acc_gnt, 0);
      tick();
      @(negedge clk);
      chk("t5_gnt", acc_gnt, 1);
      chk("t5_last", acc_last, 1);
      tick();
      acc_req = 1'b0;
      @(negedge clk);
      chk("t5_hb_gnt", acc_gnt, 0);

      // 6: reset during beat 2 of 8
      tick();
      acc_req       = 1'b1;
      acc_burst_len = 8'd8;
      acc_addr      = 32'h80;
      tick();
      tick();
      cpu_mem_en = 1'b1;
      cpu_we     = 1'b1;
      #1;
      chk("t6_pre_gnt", acc_gnt, 1);
      chk("t6_pre_stall", cpu_stall, 1);
      reset = 1'b0;
      #1;
      chk("t6_rst_gnt", acc_gnt, 0);
      chk("t6_rst_stall", cpu_stall, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_we", mem_we, 0);
      acc_req = 1'b0;
      @(posedge clk);
      #2;
      reset     = 1'b1;
      cpu_addr  = 32'h48;
      cpu_wdata = 32'h0000_CAFE;
      @(negedge clk);
      chk("t6_post_we", mem_we, 1);
      chk("t6_post_wdata", mem_wdata, 32'h0000_CAFE);
      chk("t6_post_stall", cpu_stall, 0);
      tick();
      cpu_mem_en = 1'b0;
      cpu_we     = 1'b0;
      acc_req    = 1'b1;
      @(negedge clk);
      chk("t6_post_arb", acc_gnt, 0);
      tick();
      @(negedge clk);
      chk("t6_post_gnt", acc_gnt, 1);
      chk("t6_post_rdata", acc_rdata, 0);
      acc_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
